// File: rtl/board_support_pkg.sv
// Shared types and default constants for the board-support block.
// Optional auto-repeat is enabled with the BTN_AUTOREPEAT_EN macro.
package board_support_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STRETCH   = 2'd1,
        S_RUN       = 2'd2
    } por_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_POR_CYCLES      = 256;
    localparam int DEF_HEARTBEAT_DIV   = 25174014;

    // Counter width for a count that runs 0..limit-1, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, debounce, press/release pulses.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeated press pulses.
module btn_debounce
    import board_support_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 6293504,
    parameter int REPEAT_PERIOD   = 2517401
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_b;
    logic [DW-1:0]          db_cnt;
    logic                   accept;
    logic                   rpt_fire;

    assign sync_b = sync_q[SYNC_STAGES-1];
    assign accept = (sync_b != level) && (db_cnt == DB_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // Any return to the current level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if ((sync_b == level) || accept) begin
            db_cnt <= '0;
            if (accept) begin
                level <= sync_b;
            end
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] DELAY_TOP  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TOP = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_phase;

    // A repeat never coincides with an accepted release edge.
    assign rpt_fire = run && level && !accept &&
                      (rpt_cnt == (rpt_phase ? PERIOD_TOP : DELAY_TOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (!run || !level || accept) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= run && ((accept && sync_b) || rpt_fire);
            release_pulse <= run && accept && !sync_b;
        end
    end

endmodule

// File: rtl/board_support_ctrl.sv
// Board-support top: PLL-lock reset sequencer, button conditioning, heartbeat LED.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses on held buttons.
module board_support_ctrl
    import board_support_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int POR_CYCLES      = DEF_POR_CYCLES,
    parameter int HEARTBEAT_DIV   = DEF_HEARTBEAT_DIV,
    parameter int REPEAT_DELAY    = 6293504,
    parameter int REPEAT_PERIOD   = 2517401
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pll_locked,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic               o_rst_n,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_release,
    output logic               o_heartbeat
);

    localparam int PW = cnt_width(POR_CYCLES);
    localparam int HW = cnt_width(HEARTBEAT_DIV);
    localparam logic [PW-1:0] POR_TOP = PW'(POR_CYCLES - 1);
    localparam logic [HW-1:0] HB_TOP  = HW'(HEARTBEAT_DIV - 1);

    if ((NUM_BTN < 1) || (NUM_BTN > 16) || (SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) ||
        (POR_CYCLES < 1) || (HEARTBEAT_DIV < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1))
    begin : g_bad_cfg
        $error("board_support_ctrl: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] lock_q;
    logic                   lock_s;
    por_state_e             state;
    por_state_e             next_state;
    logic [PW-1:0]          por_cnt;
    logic [PW-1:0]          por_cnt_next;
    logic                   rst_next;
    logic [HW-1:0]          hb_cnt;

    assign lock_s = lock_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else begin
            lock_q <= {lock_q[SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT_LOCK;
            por_cnt <= '0;
            o_rst_n <= 1'b0;
        end else begin
            state   <= next_state;
            por_cnt <= por_cnt_next;
            o_rst_n <= rst_next;
        end
    end

    // Losing lock anywhere drops straight back to waiting.
    always_comb begin
        next_state = state;
        if (!lock_s) begin
            next_state = S_WAIT_LOCK;
        end else begin
            case (state)
                S_WAIT_LOCK: next_state = S_STRETCH;
                S_STRETCH:   if (por_cnt == POR_TOP) next_state = S_RUN;
                S_RUN:       next_state = S_RUN;
                default:     next_state = S_WAIT_LOCK;
            endcase
        end
    end

    // The stretch counter only advances while staying in S_STRETCH.
    always_comb begin
        rst_next     = (next_state == S_RUN);
        por_cnt_next = '0;
        if ((state == S_STRETCH) && (next_state == S_STRETCH)) begin
            por_cnt_next = por_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt      <= '0;
            o_heartbeat <= 1'b0;
        end else if (hb_cnt == HB_TOP) begin
            hb_cnt      <= '0;
            o_heartbeat <= ~o_heartbeat;
        end else begin
            hb_cnt      <= hb_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_btn (
            .clk           (clk),
            .rst_n         (rst_n),
            .run           (o_rst_n),
            .btn           (i_btn[g]),
            .level         (o_btn_level[g]),
            .press         (o_btn_press[g]),
            .release_pulse (o_btn_release[g])
        );
    end

endmodule

// File: tb/tb_board_support_ctrl.sv
// Directed self-checking bench for board_support_ctrl with small counter limits.
// Auto-repeat expectations follow the BTN_AUTOREPEAT_EN macro.
module tb_board_support_ctrl;

    localparam int NB = 4;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic RPT = 1'b1;
`else
    localparam logic RPT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lock;
    logic [NB-1:0] btn;
    logic          core_rst_n;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          hb;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    board_support_ctrl #(
        .NUM_BTN         (NB),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .POR_CYCLES      (8),
        .HEARTBEAT_DIV   (5),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pll_locked  (lock),
        .i_btn         (btn),
        .o_rst_n       (core_rst_n),
        .o_btn_level   (level),
        .o_btn_press   (press),
        .o_btn_release (rel),
        .o_heartbeat   (hb)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [NB-1:0] b);
        rst_n = r;
        lock  = l;
        btn   = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hard time limit so a stuck design still produces a verdict.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NB-1:0] seen;

        applyStimulus(1'b0, 1'b0, 4'b0000);
        tick(2);
        checkOutput("reset_core_rst", core_rst_n, 0);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_press", press, 0);
        checkOutput("reset_release", rel, 0);
        checkOutput("reset_hb", hb, 0);

        $display("[TB] power-up sequence and heartbeat");
        applyStimulus(1'b1, 1'b1, 4'b0000);
        tick(4);
        checkOutput("hb_e4", hb, 0);
        checkOutput("por_e4", core_rst_n, 0);
        tick(1);
        checkOutput("hb_e5", hb, 1);
        tick(5);
        checkOutput("hb_e10", hb, 0);
        checkOutput("por_e10", core_rst_n, 0);
        tick(1);
        checkOutput("por_e11", core_rst_n, 1);
        tick(4);
        checkOutput("hb_e15", hb, 1);
        tick(2);

        $display("[TB] rst_n pulse mid-count");
        rst_n = 1'b0;
        #1;
        checkOutput("async_hb_clear", hb, 0);
        checkOutput("async_core_rst", core_rst_n, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checkOutput("hb_restart_e4", hb, 0);
        tick(1);
        checkOutput("hb_restart_e5", hb, 1);
        tick(5);
        checkOutput("hb_restart_e10", hb, 0);
        checkOutput("por_restart_e10", core_rst_n, 0);
        tick(1);
        checkOutput("por_restart_e11", core_rst_n, 1);

        $display("[TB] glitch and clean press/release on button 1");
        seen = '0;
        btn  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen = seen | level | press | rel;
        end
        btn = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen = seen | level | press | rel;
        end
        checkOutput("glitch_no_event", seen, 0);
        btn = 4'b0010;
        tick(5);
        checkOutput("press_e5_level", level, 4'b0000);
        checkOutput("press_e5_pulse", press, 4'b0000);
        tick(1);
        checkOutput("press_e6_level", level, 4'b0010);
        checkOutput("press_e6_pulse", press, 4'b0010);
        tick(1);
        checkOutput("press_e7_pulse", press, 4'b0000);
        btn = 4'b0000;
        tick(5);
        checkOutput("release_e5_pulse", rel, 4'b0000);
        checkOutput("release_e5_level", level, 4'b0010);
        tick(1);
        checkOutput("release_e6_pulse", rel, 4'b0010);
        checkOutput("release_e6_level", level, 4'b0000);
        tick(1);
        checkOutput("release_e7_pulse", rel, 4'b0000);

        $display("[TB] lock loss and recovery");
        lock = 1'b0;
        tick(2);
        checkOutput("lockloss_e2", core_rst_n, 1);
        tick(1);
        checkOutput("lockloss_e3", core_rst_n, 0);
        lock = 1'b1;
        tick(10);
        checkOutput("relock_e10", core_rst_n, 0);
        tick(1);
        checkOutput("relock_e11", core_rst_n, 1);

        $display("[TB] buttons held across reset release");
        lock = 1'b0;
        tick(3);
        checkOutput("held_core_rst_low", core_rst_n, 0);
        seen = '0;
        btn  = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen = seen | press;
        end
        checkOutput("held_level", level, 4'b1001);
        lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | press;
        end
        checkOutput("held_core_rst_high", core_rst_n, 1);
        checkOutput("held_no_press", seen, 0);
        btn = 4'b0000;
        tick(5);
        checkOutput("multi_release_e5", rel, 4'b0000);
        tick(1);
        checkOutput("multi_release_e6", rel, 4'b1001);
        checkOutput("multi_release_level", level, 4'b0000);
        tick(1);
        checkOutput("multi_release_e7", rel, 4'b0000);

        $display("[TB] long hold on button 0");
        btn = 4'b0001;
        tick(5);
        checkOutput("hold_e5", press, 4'b0000);
        tick(1);
        checkOutput("hold_press_t", press, 4'b0001);
        tick(9);
        checkOutput("hold_t9", press, 4'b0000);
        tick(1);
        checkOutput("hold_t10", press, {3'b000, RPT});
        tick(2);
        checkOutput("hold_t12", press, 4'b0000);
        tick(1);
        checkOutput("hold_t13", press, {3'b000, RPT});
        tick(3);
        checkOutput("hold_t16", press, {3'b000, RPT});
        btn = 4'b0000;
        tick(5);
        checkOutput("hold_release_e5", rel, 4'b0000);
        tick(1);
        checkOutput("hold_release_e6", rel, 4'b0001);
        checkOutput("hold_release_press", press, 4'b0000);
        tick(1);
        checkOutput("hold_after_press", press, 4'b0000);
        checkOutput("hold_after_level", level, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/board_support_ctrl.md
Name: board_support_ctrl

Overview:
Parametrised board-support block placed between FPGA board pins and the game core. It sequences the core reset from PLL lock plus a power-on stretch, and conditions NUM_BTN raw button inputs (synchroniser, debounce, press/release pulses). It also drives a heartbeat LED. It replaces ad-hoc power-on counters and raw button wiring in per-board top levels.

Parameters:
NUM_BTN, 4, number of button channels (1..16)
SYNC_STAGES, 2, synchroniser flops per async input (>=2)
DEBOUNCE_CYCLES, 250000, cycles an input must stay stable before it is accepted (>=1)
POR_CYCLES, 256, reset stretch after lock, in cycles (>=1)
HEARTBEAT_DIV, 25174014, cycles per heartbeat toggle (>=2)
REPEAT_DELAY, 6293504, cycles held before the first auto-repeat (used only with the macro)
REPEAT_PERIOD, 2517401, cycles between auto-repeats (used only with the macro)

Ports:
clk  in  1  system clock (VGA pixel clock)
rst_n  in  1  asynchronous active-low reset
i_pll_locked  in  1  PLL/MMCM lock, asynchronous
i_btn  in  NUM_BTN  raw buttons, active-high, asynchronous
o_rst_n  out  1  core reset: asserted asynchronously, deasserted synchronously
o_btn_level  out  NUM_BTN  debounced button level
o_btn_press  out  NUM_BTN  one-cycle pulse on accepted rising edge
o_btn_release  out  NUM_BTN  one-cycle pulse on accepted falling edge
o_heartbeat  out  1  toggles every HEARTBEAT_DIV cycles

Behaviour:
- rst_n low: all flops clear at once. o_rst_n=0, levels/pulses=0, o_heartbeat=0, FSM=S_WAIT_LOCK.
- Reset FSM runs on the synchronised lock signal (lock_s, SYNC_STAGES flops).
  - S_WAIT_LOCK: counter=0. When lock_s=1, go to S_STRETCH with counter=0.
  - S_STRETCH: counter increments each cycle. On the edge where counter==POR_CYCLES-1, go to S_RUN.
  - S_RUN: hold.
  - lock_s=0 in any state: go to S_WAIT_LOCK and clear the counter.
- o_rst_n is a flop loaded with (next_state==S_RUN). It rises exactly SYNC_STAGES+POR_CYCLES+1 edges after i_pll_locked rises. It falls on the edge after lock_s falls.
- Debounce, per channel:
  - sync_b (SYNC_STAGES flops) is compared with level.
  - Equal: cnt=0.
  - Differ: cnt increments. On the edge where cnt==DEBOUNCE_CYCLES-1: level<=sync_b, cnt<=0, and press (0->1) or release (1->0) is registered on the same edge.
  - Latency from a raw change to level: SYNC_STAGES+DEBOUNCE_CYCLES edges.
  - Any glitch shorter than DEBOUNCE_CYCLES resets cnt and produces no event.
- Pulses are gated with o_rst_n. Levels track regardless. A button held across reset release gives level=1 and no press pulse.
- Heartbeat: hb_cnt runs 0..HEARTBEAT_DIV-1. It toggles o_heartbeat and wraps to 0 at the top value. It free-runs from rst_n release, independent of lock.
- Widths: every counter is $clog2(limit) bits, minimum 1. No counter ever exceeds its limit.
- Simultaneous press on several channels: every channel pulses in the same cycle. Channels are independent.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: while level=1 in S_RUN, a per-channel repeat counter emits an extra o_btn_press pulse REPEAT_DELAY cycles after the accepted press. It then pulses every REPEAT_PERIOD cycles. Release or o_rst_n=0 clears the repeat counter.
- Undefined: exactly one press pulse per accepted press. The repeat logic and its counters are absent, and the REPEAT_* parameters are ignored.

Decomposition:
- board_support_pkg holds:
  - typedef enum logic [1:0] por_state_e {S_WAIT_LOCK, S_STRETCH, S_RUN}.
  - Default constants: DEF_DEBOUNCE_CYCLES, DEF_POR_CYCLES, DEF_HEARTBEAT_DIV.
- Sub-module btn_debounce handles one channel: sync + debounce + edge pulses + optional repeat. It is instantiated NUM_BTN times via generate.
- The FSM and heartbeat stay in the top.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, POR_CYCLES=8, HEARTBEAT_DIV=5, NUM_BTN=4.
1. Release rst_n, raise i_pll_locked at edge 0 -> o_rst_n=0 through edge 10, o_rst_n=1 after edge 11.
2. In S_RUN, i_btn[1] high for 3 cycles then low -> no level change, no pulse. Held high -> o_btn_level[1]=1 and o_btn_press[1]=1 for one cycle after 6 edges. Drop -> o_btn_release[1] one cycle, 6 edges later.
3. Drop i_pll_locked in S_RUN -> o_rst_n=0 after 3 edges. Re-raise -> o_rst_n=1 again 11 edges later.
4. After rst_n release, o_heartbeat toggles every 5 cycles (period 10). rst_n pulse mid-count -> o_heartbeat=0 and restarts.
5. i_btn=4'b1001 held before lock -> levels=1001, no press pulses when o_rst_n rises. Release both simultaneously -> o_btn_release=1001 in one cycle.
6. With BTN_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3, hold i_btn[0] -> presses at t, t+10, t+13, t+16. Without the macro -> only the press at t.
